// File: rtl/config_pkg.sv
// User configuration record plus line geometry derived from it, shared by the
// ICache and the refill responder so both agree on line size.
package config_pkg;

  typedef struct packed {
    int unsigned XLEN;
    int unsigned ICACHE_LINE_WIDTH;
  } cfg_t;

  function automatic int unsigned ICACHE_LINE_BYTES(input cfg_t cfg);
    return cfg.ICACHE_LINE_WIDTH / 8;
  endfunction

  function automatic int unsigned ICACHE_WORDS_PER_LINE(input cfg_t cfg);
    return cfg.ICACHE_LINE_WIDTH / cfg.XLEN;
  endfunction

endpackage

// File: rtl/test_config_pkg.sv
// Default configuration: 32-bit core, 256-bit instruction cache lines.
package test_config_pkg;

  localparam config_pkg::cfg_t TestCfg = '{XLEN: 32, ICACHE_LINE_WIDTH: 256};

endpackage

// File: rtl/icache_refill_responder.sv
// Splits an ICache line refill into in-order word reads on a req/gnt/rvalid bus
// and returns the assembled line (with a sticky error flag) over valid/ready.
module icache_refill_responder
  import config_pkg::*;
#(
  parameter cfg_t Cfg = test_config_pkg::TestCfg
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic [Cfg.XLEN-1:0]               req_addr_i,
  output logic                              rsp_valid_o,
  input  logic                              rsp_ready_i,
  output logic [Cfg.ICACHE_LINE_WIDTH-1:0]  rsp_data_o,
  output logic                              rsp_err_o,
  output logic                              mem_req_o,
  output logic [Cfg.XLEN-1:0]               mem_addr_o,
  input  logic                              mem_gnt_i,
  input  logic                              mem_rvalid_i,
  input  logic [Cfg.XLEN-1:0]               mem_rdata_i,
  input  logic                              mem_err_i
);

  localparam int unsigned XLEN       = Cfg.XLEN;
  localparam int unsigned WORDS      = ICACHE_WORDS_PER_LINE(Cfg);
  localparam int unsigned LINE_BYTES = ICACHE_LINE_BYTES(Cfg);
  localparam int unsigned CNT_W      = $clog2(WORDS) + 1;
  localparam int unsigned IDX_W      = $clog2(WORDS);
  localparam int unsigned WORD_BYTES = XLEN / 8;

  localparam logic [XLEN-1:0]  LINE_MASK  = ~(XLEN'(LINE_BYTES) - XLEN'(1));
  localparam logic [CNT_W-1:0] CNT_WORDS  = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RESP
  } refill_state_e;

  refill_state_e                   state_q, state_d;
  logic [XLEN-1:0]                 base_q;
  logic [CNT_W-1:0]                issue_cnt_q;
  logic [CNT_W-1:0]                recv_cnt_q;
  logic                            err_q;
  logic [WORDS-1:0][XLEN-1:0]      line_q;

  logic                            req_take;
  logic                            issue_take;
  logic                            rvalid_take;
  logic                            recv_last;
  logic [XLEN-1:0]                 word_addr;
  logic [IDX_W-1:0]                recv_idx;

  assign req_take    = (state_q == IDLE) && req_valid_i;
  assign issue_take  = mem_req_o && mem_gnt_i;
  // A response is only legal while a granted read is still outstanding.
  assign rvalid_take = (state_q == FILL) && mem_rvalid_i && (recv_cnt_q != issue_cnt_q);
  assign recv_last   = rvalid_take && (recv_cnt_q == CNT_LAST);
  assign word_addr   = base_q + (XLEN'(issue_cnt_q) * XLEN'(WORD_BYTES));
  assign recv_idx    = recv_cnt_q[IDX_W-1:0];

  assign rsp_data_o  = line_q;
  assign rsp_err_o   = err_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d     = state_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_addr_o  = '0;
    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = FILL;
      end
      FILL: begin
        mem_req_o = (issue_cnt_q < CNT_WORDS);
        if (mem_req_o) mem_addr_o = word_addr;
        if (recv_last) state_d = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_q      <= '0;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else if (req_take) begin
      base_q      <= req_addr_i & LINE_MASK;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else if (state_q == FILL) begin
      if (issue_take) issue_cnt_q <= issue_cnt_q + CNT_W'(1);
      if (rvalid_take) begin
        recv_cnt_q <= recv_cnt_q + CNT_W'(1);
        err_q      <= err_q | mem_err_i;
      end
    end
  end

  // NOTE: the line buffer is reset because rsp_data_o must read zero out of reset;
  // it is deliberately not cleared per request since every slot is rewritten before RESP.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      line_q <= '0;
    end else if (rvalid_take) begin
      line_q[recv_idx] <= mem_rdata_i;
    end
  end

  stray_rvalid_a: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    mem_rvalid_i |-> ((state_q == FILL) && (recv_cnt_q != issue_cnt_q))
  );

  req_held_a: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (mem_req_o && !mem_gnt_i) |=> (mem_req_o && $stable(mem_addr_o))
  );

endmodule

// File: tb/tb_icache_refill_responder.sv
// Directed bench for icache_refill_responder: a small in-order memory model with
// configurable grant/response delays feeds the DUT, expected lines come from constants.
module tb_icache_refill_responder;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         req_valid_i;
  logic         req_ready_o;
  logic [31:0]  req_addr_i;
  logic         rsp_valid_o;
  logic         rsp_ready_i;
  logic [255:0] rsp_data_o;
  logic         rsp_err_o;
  logic         mem_req_o;
  logic [31:0]  mem_addr_o;
  logic         mem_gnt_i;
  logic         mem_rvalid_i;
  logic [31:0]  mem_rdata_i;
  logic         mem_err_i;

  always #5 clk_i = ~clk_i;

  icache_refill_responder dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_addr_i   (req_addr_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_data_o   (rsp_data_o),
    .rsp_err_o    (rsp_err_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .mem_err_i    (mem_err_i)
  );

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Memory model configuration and state.
  typedef struct {
    logic [31:0] data;
    logic        err;
    int          ready;
  } rsp_t;

  int          gnt_max   = 0;
  int          lat_max   = 0;
  int          err_word  = -1;
  logic [31:0] data_key  = 32'h0;
  int          gnt_wait  = 0;
  int          cyc       = 0;
  int          last_ready = 0;
  bit          stalled   = 1'b0;
  logic [31:0] stall_addr;
  logic [31:0] issued[$];
  rsp_t        pend[$];

  task automatic configure(input int g, input int l, input logic [31:0] key, input int ew);
    gnt_max  = g;
    lat_max  = l;
    data_key = key;
    err_word = ew;
    gnt_wait = 0;
  endtask

  initial begin
    rsp_t r;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    mem_err_i    = 1'b0;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (!rst_ni) begin
        pend.delete();
        last_ready   = 0;
        stalled      = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_err_i    = 1'b0;
      end else begin
        if (pend.size() > 0 && pend[0].ready <= cyc) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = pend[0].data;
          mem_err_i    = pend[0].err;
          void'(pend.pop_front());
        end else begin
          mem_rvalid_i = 1'b0;
          mem_err_i    = 1'b0;
        end
        if (mem_req_o) begin
          if (stalled) check("addr_stable", mem_addr_o, stall_addr);
          if (gnt_wait <= 0) begin
            r.data  = mem_addr_o ^ data_key;
            r.err   = (int'(mem_addr_o[4:2]) == err_word);
            r.ready = cyc + 1 + int'($urandom_range(lat_max, 0));
            if (r.ready < last_ready) r.ready = last_ready;
            last_ready = r.ready;
            pend.push_back(r);
            issued.push_back(mem_addr_o);
            mem_gnt_i = 1'b1;
            gnt_wait  = int'($urandom_range(gnt_max, 0));
            stalled   = 1'b0;
          end else begin
            gnt_wait--;
            mem_gnt_i  = 1'b0;
            stalled    = 1'b1;
            stall_addr = mem_addr_o;
          end
        end else begin
          if (stalled) check("req_held", mem_req_o, 1'b1);
          stalled   = 1'b0;
          mem_gnt_i = 1'b0;
        end
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_req_ready"}, req_ready_o, 1'b1);
    check({tag, "_rsp_valid"}, rsp_valid_o, 1'b0);
    check({tag, "_mem_req"},   mem_req_o,   1'b0);
    check({tag, "_rsp_err"},   rsp_err_o,   1'b0);
    check({tag, "_mem_addr"},  mem_addr_o,  32'h0);
    check({tag, "_rsp_data"},  rsp_data_o,  256'h0);
  endtask

  // One full refill: request, wait for the line, check it, optionally hold it, accept it.
  task automatic do_fill(input string tag, input logic [31:0] addr, input logic [31:0] exp_base,
                         input logic exp_err, input int bp, input int exp_lat);
    int           lat;
    logic [255:0] exp_line;
    for (int k = 0; k < 8; k++) exp_line[k*32 +: 32] = (exp_base + 32'(4 * k)) ^ data_key;
    issued.delete();
    @(negedge clk_i);
    check({tag, "_req_ready"}, req_ready_o, 1'b1);
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    lat = 1;
    @(negedge clk_i);
    while (!rsp_valid_o && lat < 300) begin
      @(negedge clk_i);
      lat++;
    end
    if (!rsp_valid_o) begin
      check({tag, "_rsp_timeout"}, rsp_valid_o, 1'b1);
      return;
    end
    if (exp_lat > 0) check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_issue_count"}, issued.size(), 8);
    for (int k = 0; k < 8 && k < issued.size(); k++)
      check($sformatf("%s_addr%0d", tag, k), issued[k], exp_base + 32'(4 * k));
    for (int k = 0; k < 8; k++)
      check($sformatf("%s_word%0d", tag, k), rsp_data_o[k*32 +: 32], exp_line[k*32 +: 32]);
    check({tag, "_err"}, rsp_err_o, exp_err);
    for (int i = 0; i < bp; i++) begin
      check($sformatf("%s_hold_valid%0d", tag, i), rsp_valid_o, 1'b1);
      check($sformatf("%s_hold_data%0d", tag, i), rsp_data_o, exp_line);
      check($sformatf("%s_hold_err%0d", tag, i), rsp_err_o, exp_err);
      check($sformatf("%s_hold_busy%0d", tag, i), req_ready_o, 1'b0);
      @(negedge clk_i);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1 rsp_ready_i = 1'b0;
    @(negedge clk_i);
    check({tag, "_idle_after_rsp"}, req_ready_o, 1'b1);
    check({tag, "_valid_dropped"}, rsp_valid_o, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst_ni      = 1'b0;
    req_valid_i = 1'b0;
    req_addr_i  = '0;
    rsp_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check_reset("por");
    #1 rst_ni = 1'b1;

    // Basic fill: data = address, single-cycle memory.
    configure(0, 0, 32'h0, -1);
    do_fill("basic", 32'h8000_0014, 32'h8000_0000, 1'b0, 0, 10);

    // Random grant and response delays.
    configure(5, 5, 32'hA5A5_0000, -1);
    do_fill("rand0", 32'h1234_5678, 32'h1234_5660, 1'b0, 0, 0);
    do_fill("rand1", 32'h0000_003F, 32'h0000_0020, 1'b0, 0, 0);
    do_fill("rand2", 32'h7FFF_FFE1, 32'h7FFF_FFE0, 1'b0, 0, 0);

    // Bus error on word 5, then a clean fill clears the flag.
    configure(1, 2, 32'h0F0F_0F0F, 5);
    do_fill("err5", 32'h0000_1000, 32'h0000_1000, 1'b1, 0, 0);
    configure(1, 2, 32'h0F0F_0F0F, -1);
    do_fill("clean", 32'h0000_2004, 32'h0000_2000, 1'b0, 0, 0);

    // Response backpressure for 7 cycles.
    configure(0, 0, 32'h1111_2222, -1);
    do_fill("bp", 32'h4000_0080, 32'h4000_0080, 1'b0, 7, 10);

    // Top-of-memory line: addresses wrap within the line only.
    configure(0, 0, 32'h0, -1);
    do_fill("wrap", 32'hFFFF_FFF0, 32'hFFFF_FFE0, 1'b0, 0, 10);

    // Reset after three grants, then a normal fill.
    configure(0, 3, 32'h0, -1);
    issued.delete();
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_addr_i  = 32'h3000_0008;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    n = 0;
    while (issued.size() < 3 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    check("mid_three_grants", issued.size() >= 3, 1'b1);
    @(posedge clk_i);
    #1 rst_ni = 1'b0;
    #1 check_reset("midrst");
    repeat (2) @(negedge clk_i);
    #1 rst_ni = 1'b1;
    configure(0, 0, 32'h5555_0000, -1);
    do_fill("after_rst", 32'h9000_0044, 32'h9000_0040, 1'b0, 0, 10);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/icache_refill_responder.md
# icache_refill_responder

- Memory-side responder for instruction-cache line refills.
- Accepts one line-fill request at a time from the ICache miss path and splits it into `XLEN`-wide word reads on a simple pipelined memory bus (req/gnt/rvalid).
- Assembles the returned words into one `ICACHE_LINE_WIDTH`-bit line and returns it to the cache through a valid/ready response channel.
- Sits between the ICache and the instruction memory / bus bridge.

## Interface

Reset: one clock; reset is asynchronous and active-low.

Parameters:
- `Cfg`, default `test_config_pkg::TestCfg`, user configuration. The block uses only `XLEN` (32) and `ICACHE_LINE_WIDTH` (256).
- Derived, not overridable:
  - `WORDS = ICACHE_LINE_WIDTH/XLEN` (8).
  - `LINE_BYTES = ICACHE_LINE_WIDTH/8` (32).
  - `CNT_W = $clog2(WORDS)+1`.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `req_valid_i` in 1: refill request valid.
- `req_ready_o` out 1: responder idle and able to accept a request.
- `req_addr_i` in `XLEN`: miss address. Any byte address; low `log2(LINE_BYTES)` bits are ignored.
- `rsp_valid_o` out 1: assembled line valid.
- `rsp_ready_i` in 1: cache accepts the line.
- `rsp_data_o` out `ICACHE_LINE_WIDTH`: line data. Word k occupies bits `[k*XLEN +: XLEN]`.
- `rsp_err_o` out 1: at least one word returned with a bus error.
- `mem_req_o` out 1: word read request.
- `mem_addr_o` out `XLEN`: word address, word-aligned.
- `mem_gnt_i` in 1: request accepted this cycle.
- `mem_rvalid_i` in 1: read data valid. Responses return in order.
- `mem_rdata_i` in `XLEN`: read data.
- `mem_err_i` in 1: error flag, qualified by `mem_rvalid_i`.

## Operation

State machine with three states: `IDLE`, `FILL`, `RESP`.

`IDLE`:
- `req_ready_o=1`.
- On `req_valid_i`:
  - latch `base = req_addr_i & ~(LINE_BYTES-1)`;
  - clear `issue_cnt`, `recv_cnt` and `err`;
  - go to `FILL`.

`FILL`:
- Issue side:
  - `mem_req_o = (issue_cnt < WORDS)`;
  - `mem_addr_o = base + issue_cnt*(XLEN/8)`;
  - `issue_cnt` increments on `mem_req_o & mem_gnt_i`.
- Receive side:
  - on `mem_rvalid_i`, write `mem_rdata_i` into word slot `recv_cnt`;
  - `err |= mem_err_i`;
  - `recv_cnt` increments.
- Issue and receive run concurrently: up to `WORDS` reads outstanding, no stall between grants.
- When `mem_rvalid_i` arrives with `recv_cnt == WORDS-1`, go to `RESP`.

`RESP`:
- `rsp_valid_o=1`.
- `rsp_data_o` and `rsp_err_o` are held stable.
- Go to `IDLE` on `rsp_ready_i`.

Error handling:
- A word with `mem_err_i` is still stored and the fill continues to all `WORDS`.
- No early abort; `rsp_err_o` is sticky for the line.

Address arithmetic:
- Computed modulo 2^`XLEN`.
- Because `base` is line-aligned, the addresses never cross a line.

Stray responses:
- `mem_rvalid_i` with no outstanding read (`recv_cnt == issue_cnt`) or outside `FILL` is a protocol violation.
- It is ignored and flagged by an assertion.

## Timing

- Reset values:
  - state `IDLE`, so `req_ready_o=1`;
  - `rsp_valid_o=0`, `mem_req_o=0`, `rsp_err_o=0`;
  - `mem_addr_o=0`, `rsp_data_o=0`;
  - counters 0.
- A request handshake in cycle T puts `mem_req_o=1` with word 0's address in T+1.
- Best case (`mem_gnt_i` held 1, `rvalid` one cycle after grant):
  - grants in T+1..T+8;
  - `rvalid` in T+2..T+9;
  - `rsp_valid_o=1` in T+10.
- `rsp_valid_o` rises in the cycle after the last `rvalid` and stays high until handshaken.
- `req_ready_o` returns to 1 in the cycle after the response handshake. The same-cycle response-and-new-request path is not supported.
- `mem_req_o` stays asserted and `mem_addr_o` stays stable until granted. The request is never withdrawn.
- A grant and an `rvalid` in the same cycle both take effect.
- `rsp_data_o` is not cleared on a new request. Each slot is overwritten before `RESP`.
- `rst_ni` asserted mid-fill or mid-response:
  - immediate return to `IDLE` and all outputs to reset values;
  - in-flight bus responses after reset release are ignored as stray.

## Structure

- `config_pkg` gains the derived constants `ICACHE_LINE_BYTES` and `ICACHE_WORDS_PER_LINE`, computed from the user config, so the ICache and the responder share them.
- The state enum `refill_state_e` is local to the module.
- Single module, no sub-module. The line buffer is a packed `WORDS x XLEN` register array written by index.

## Test plan

- **Basic fill.** Request `req_addr_i=0x8000_0014`, memory always grants, data = address, rvalid latency 1.
  - Required: `mem_addr_o` = `0x8000_0000`..`0x8000_001C`.
  - `rsp_data_o` word k = `0x8000_0000+4k`.
  - `rsp_valid_o` at T+10, `rsp_err_o=0`.
- **Random grant and response delays** (0-5 cycles).
  - Required: every address issued exactly once, in order, and the line is correct.
  - Required: `mem_addr_o` stays stable while `mem_gnt_i=0`.
- **Error on word 5.** `mem_err_i=1` on word 5 only.
  - Required: all 8 words still fetched and `rsp_err_o=1`.
  - The next clean fill reports `rsp_err_o=0`.
- **Response backpressure.** Hold `rsp_ready_i=0` for 7 cycles.
  - Required: `rsp_valid_o`, `rsp_data_o` and `rsp_err_o` stay stable.
  - Required: `req_ready_o=0` throughout; `IDLE` is reached one cycle after `rsp_ready_i=1`.
- **Address wrap.** Request `req_addr_i=0xFFFF_FFF0`.
  - Required: addresses `0xFFFF_FFE0`..`0xFFFF_FFFC`, no carry into an extra word.
- **Mid-fill reset.** Pulse `rst_ni` low after 3 grants.
  - Required: outputs at reset values, `req_ready_o=1`.
  - Required: a following request produces a correct line.
